imm_packer: RTL and testbench

- Inverse of the immediate extender: takes a 32-bit immediate plus an instruction template and packs the immediate into the RISC-V I/S/B/J/U bit positions, producing a complete 32-bit instruction word.
- Feeds the instruction-memory loader and test-program generator.
- Two-stage valid/ready pipeline with range and alignment checking, and statistics counters.

---
 rtl/imm_packer.sv | 187 ++++++++++++++++++
 tb/tb_imm_packer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// imm_packer: packs a 32-bit immediate into a RISC-V I/S/B/J/U instruction template,
// two-stage valid/ready pipeline with checks and counters. Optional: IMM_PACK_SELFCHECK_EN.
module imm_packer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       immsrc,
    input  logic [31:0]      imm,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] pack_count,
    output logic [CNT_W-1:0] err_count,
    output logic             selfcheck_fail
);

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_RANGE   = 2'b01,
        ERR_ALIGN   = 2'b10,
        ERR_ILLEGAL = 2'b11
    } err_e;

    logic             s1_valid_q;
    logic [2:0]       s1_immsrc_q;
    logic [31:0]      s1_imm_q;
    logic [31:0]      s1_base_q;
    err_e             s1_err_q;
    logic             s2_valid_q;
    logic [31:0]      s2_instr_q;
    err_e             s2_err_q;
    logic [CNT_W-1:0] pack_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    err_e             chk_err_d;
    logic [31:0]      pack_d;
    logic             range_ok;
    logic             align_ok;
    logic             s2_load;
    logic             s1_advance;
    logic             in_xfer;
    logic             out_xfer;

    assign s2_load    = !s2_valid_q || out_ready;
    assign s1_advance = s1_valid_q && s2_load;
    assign in_ready   = !s1_valid_q || s1_advance;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = s2_valid_q && out_ready;

    // Checks run on the raw inputs so S1 holds the verdict alongside the operands.
    always_comb begin
        range_ok  = 1'b1;
        align_ok  = 1'b1;
        chk_err_d = ERR_OK;
        case (fmt_e'(immsrc))
            FMT_I, FMT_S: range_ok = (imm[31:11] == {21{imm[11]}});
            FMT_B: begin
                range_ok = (imm[31:12] == {20{imm[12]}});
                align_ok = !imm[0];
            end
            FMT_J: begin
                range_ok = (imm[31:20] == {12{imm[20]}});
                align_ok = !imm[0];
            end
            FMT_U:   range_ok = (imm[11:0] == '0);
            default: ;
        endcase
        if (immsrc > 3'b100)
            chk_err_d = ERR_ILLEGAL;
        else if (!align_ok)
            chk_err_d = ERR_ALIGN;
        else if (!range_ok)
            chk_err_d = ERR_RANGE;
    end

    always_comb begin
        pack_d = s1_base_q;
        case (fmt_e'(s1_immsrc_q))
            FMT_I: pack_d[31:20] = s1_imm_q[11:0];
            FMT_S: begin
                pack_d[31:25] = s1_imm_q[11:5];
                pack_d[11:7]  = s1_imm_q[4:0];
            end
            FMT_B: begin
                pack_d[31]    = s1_imm_q[12];
                pack_d[7]     = s1_imm_q[11];
                pack_d[30:25] = s1_imm_q[10:5];
                pack_d[11:8]  = s1_imm_q[4:1];
            end
            FMT_J: begin
                pack_d[31]    = s1_imm_q[20];
                pack_d[19:12] = s1_imm_q[19:12];
                pack_d[20]    = s1_imm_q[11];
                pack_d[30:21] = s1_imm_q[10:1];
            end
            FMT_U:   pack_d[31:12] = s1_imm_q[31:12];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_immsrc_q <= '0;
            s1_imm_q    <= '0;
            s1_base_q   <= '0;
            s1_err_q    <= ERR_OK;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= '0;
            s2_err_q    <= ERR_OK;
            pack_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid_q  <= 1'b1;
                s1_immsrc_q <= immsrc;
                s1_imm_q    <= imm;
                s1_base_q   <= base;
                s1_err_q    <= chk_err_d;
            end else if (s1_advance) begin
                s1_valid_q  <= 1'b0;
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_instr_q <= pack_d;
                    s2_err_q   <= s1_err_q;
                end
            end
            if (out_xfer && pack_cnt_q != '1)
                pack_cnt_q <= pack_cnt_q + 1'b1;
            if (out_xfer && s2_err_q != ERR_OK && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

`ifdef IMM_PACK_SELFCHECK_EN
    logic [31:0] dec_d;
    logic        selfcheck_fail_q;

    // Decode the freshly packed word back exactly as the extender would.
    always_comb begin
        dec_d = '0;
        case (fmt_e'(s1_immsrc_q))
            FMT_I:   dec_d = {{20{pack_d[31]}}, pack_d[31:20]};
            FMT_S:   dec_d = {{20{pack_d[31]}}, pack_d[31:25], pack_d[11:7]};
            FMT_B:   dec_d = {{19{pack_d[31]}}, pack_d[31], pack_d[7], pack_d[30:25],
                              pack_d[11:8], 1'b0};
            FMT_J:   dec_d = {{11{pack_d[31]}}, pack_d[31], pack_d[19:12], pack_d[20],
                              pack_d[30:21], 1'b0};
            FMT_U:   dec_d = {pack_d[31:12], 12'b0};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            selfcheck_fail_q <= 1'b0;
        else if (s1_advance && s1_err_q == ERR_OK && dec_d != s1_imm_q)
            selfcheck_fail_q <= 1'b1;
    end

    assign selfcheck_fail = selfcheck_fail_q;
`else
    assign selfcheck_fail = 1'b0;
`endif

    assign out_valid  = s2_valid_q;
    assign instr      = s2_instr_q;
    assign err_code   = s2_err_q;
    assign pack_count = pack_cnt_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_imm_packer.sv
// Directed vector table plus backpressure, reset and random-stream sequences for imm_packer.
module tb_imm_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  immsrc;
    logic [31:0] imm;
    logic [31:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [1:0]  err_code;
    logic [15:0] pack_count;
    logic [15:0] err_count;
    logic        selfcheck_fail;

    imm_packer #(.CNT_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .immsrc         (immsrc),
        .imm            (imm),
        .base           (base),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instr          (instr),
        .err_code       (err_code),
        .pack_count     (pack_count),
        .err_count      (err_count),
        .selfcheck_fail (selfcheck_fail)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] exp_instr;
        logic [1:0]  exp_err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic gen_legal(output logic [2:0] s, output logic [31:0] v);
        logic [31:0] r;
        r = $urandom;
        s = 3'($urandom_range(0, 4));
        case (s)
            3'd0, 3'd1: v = {{20{r[11]}}, r[11:0]};
            3'd2:       v = {{19{r[12]}}, r[12:1], 1'b0};
            3'd3:       v = {{11{r[20]}}, r[20:1], 1'b0};
            default:    v = {r[31:12], 12'b0};
        endcase
    endtask

    initial begin
        int lat;
        int n_err;
        int stale;
        int sent;
        int got;
        int cyc;
        logic acc;

        vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 2'b00};
        vecs[1]  = '{3'b001, 32'h0000_0008, 32'h0000_2023, 32'h0000_2423, 2'b00};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 2'b00};
        vecs[3]  = '{3'b011, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 2'b00};
        vecs[4]  = '{3'b100, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 2'b00};
        vecs[5]  = '{3'b010, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 2'b10};
        vecs[6]  = '{3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 2'b01};
        vecs[7]  = '{3'b111, 32'h0000_0005, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11};
        vecs[8]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_2023, 32'hFE00_2FA3, 2'b00};
        vecs[9]  = '{3'b011, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 2'b01};
        vecs[10] = '{3'b010, 32'h0000_1001, 32'h0000_0063, 32'h8000_0063, 2'b10};
        vecs[11] = '{3'b100, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 2'b01};
        vecs[12] = '{3'b011, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 2'b00};
        vecs[13] = '{3'b101, 32'h0000_0000, 32'h0000_0013, 32'h0000_0013, 2'b11};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        immsrc    = '0;
        imm       = '0;
        base      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset instr", instr, 0);
        check("reset err_code", err_code, 0);
        check("reset pack_count", pack_count, 0);
        check("reset err_count", err_count, 0);
        check("reset in_ready", in_ready, 1);
        check("reset selfcheck_fail", selfcheck_fail, 0);

        n_err = 0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].exp_err != 2'b00) n_err++;
            check($sformatf("vec%0d in_ready", i), in_ready, 1);
            immsrc   = vecs[i].src;
            imm      = vecs[i].imm;
            base     = vecs[i].base;
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d latency", i), lat, 2);
            check($sformatf("vec%0d instr", i), instr, vecs[i].exp_instr);
            check($sformatf("vec%0d err_code", i), err_code, vecs[i].exp_err);
        end
        @(negedge clk);
        check("table pack_count", pack_count, NV);
        check("table err_count", err_count, n_err);

        // Backpressure: two items fill the pipe, the third waits.
        out_ready = 1'b0;
        immsrc = 3'b000; base = 32'h0000_0013;
        imm = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1 imm = 32'd2;
        @(posedge clk); #1 imm = 32'd3;
        @(negedge clk);
        check("bp in_ready low", in_ready, 0);
        check("bp out_valid", out_valid, 1);
        check("bp head instr", instr, 32'h0010_0013);
        repeat (3) @(negedge clk);
        check("bp in_ready still low", in_ready, 0);
        check("bp instr stable", instr, 32'h0010_0013);
        check("bp err stable", err_code, 0);
        out_ready = 1'b1;
        #1 check("bp in_ready on release", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp second out_valid", out_valid, 1);
        check("bp second instr", instr, 32'h0020_0013);
        @(negedge clk);
        check("bp third out_valid", out_valid, 1);
        check("bp third instr", instr, 32'h0030_0013);
        @(negedge clk);
        check("bp drained", out_valid, 0);

        // Reset with both stages full.
        out_ready = 1'b0;
        imm = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1 imm = 32'd5;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("pre-reset out_valid", out_valid, 1);
        check("pre-reset in_ready", in_ready, 0);
        check("pre-reset pack_count", pack_count, NV + 3);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid reset out_valid", out_valid, 0);
        check("mid reset pack_count", pack_count, 0);
        check("mid reset err_count", err_count, 0);
        check("mid reset instr", instr, 0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post reset in_ready", in_ready, 1);
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("post reset stale outputs", stale, 0);

        // Random legal stream with random output stalls.
        sent = 0; got = 0; cyc = 0;
        gen_legal(immsrc, imm);
        base = $urandom;
        while ((sent < 1000 || got < 1000) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 1000);
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got++;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                gen_legal(immsrc, imm);
                base = $urandom;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("random delivered", got, 1000);
        @(negedge clk);
        check("random pack_count", pack_count, 1000);
        check("random err_count", err_count, 0);
        check("random selfcheck_fail", selfcheck_fail, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
